pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage TSC pipeline (IF/ID/EX/MEM/WB). It generates the pipeline-register enables, bubbles and flushes for three cases: load-use stalls, control transfers (jumps resolved in ID, branches resolved in EX) and HLT drain. It also holds the sticky halt state and saturating stall/flush performance counters. It sits beside control_unit and forwarding_unit and gates the PC and the IF/ID and ID/EX latches.

Parameters:
CNT_W, 16, width of the performance counters
DRAIN_CYCLES, 3, cycles from HLT leaving ID until it has retired from WB

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-high reset
id_opcode  in  4  opcode in the ID stage (`opcodes.v` encodings)
id_func  in  6  func code in the ID stage
id_valid  in  1  the ID-stage instruction is not a bubble
id_rs1  in  2  source register 1 in ID
id_rs2  in  2  source register 2 in ID
ex_mem_read  in  1  EX-stage instruction is LWD
ex_rd  in  2  destination register of the EX-stage instruction
ex_branch_taken  in  1  branch resolved taken in EX
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID latch enable
ifid_flush  out  1  load a bubble into IF/ID
idex_bubble  out  1  load a bubble into ID/EX
halt  out  1  processor halted (sticky)
stall_cnt  out  CNT_W  number of load-use stall cycles
flush_cnt  out  CNT_W  number of flush events

Behaviour:
- Reset (synchronous, active-high reset_n): state=RUN, drain counter=0, halt=0, stall_cnt=0, flush_cnt=0. While reset is asserted the strobe outputs are pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1.
- Register usage, decoded from id_opcode/id_func:
  - use_rs1 = ALU_OP (all funcs except HLT), ADI, ORI, LWD, SWD, BNE, BEQ, BGZ, BLZ.
  - use_rs2 = ALU_OP with ADD/SUB/AND/ORR, SWD, BNE, BEQ.
  - LHI, JMP and JAL use no source register.
- load_use = id_valid & ex_mem_read & ((use_rs1 & id_rs1==ex_rd) | (use_rs2 & id_rs2==ex_rd)).
- id_jump = id_valid & (JMP | JAL | ALU_OP with JPR or JRL).
- id_hlt = id_valid & ALU_OP & func==HLT.
- Output strobes are combinational from state and inputs. The default is pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- Priority in RUN (highest first):
  1. ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_write=1 (target loaded); flush_cnt+1. Any load_use, jump or HLT in ID is squashed.
  2. load_use: pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt+1. Exactly one bubble; the next cycle re-evaluates.
  3. id_jump: ifid_flush=1, pc_write=1; flush_cnt+1.
  4. id_hlt: go to DRAIN with drain counter=DRAIN_CYCLES-1. In the same cycle pc_write=0 and ifid_write=0, and HLT passes into ID/EX.
- DRAIN:
  - pc_write=0, ifid_write=0, idex_bubble=1. The counter decrements each cycle; at 0 go to HALTED.
  - If ex_branch_taken occurs in DRAIN (an older branch is resolving), abort: ifid_flush=1, idex_bubble=1, pc_write=1, flush_cnt+1, return to RUN. The HLT is squashed.
- HALTED: halt=1 registered and sticky; pc_write=0, ifid_write=0, idex_bubble=1. All inputs are ignored until reset.
- Counters saturate at all-ones and never wrap.
- Reset mid-DRAIN or in HALTED returns to RUN on the next edge with halt=0.
- halt rises on the clock edge that enters HALTED: DRAIN_CYCLES cycles after HLT is seen in ID.

Decomposition:
- The opcode/func constants come from the shared `opcodes.v` include.
- Add the state encodings (HZ_RUN, HZ_DRAIN, HZ_HALTED) to the same shared include.
- Natural sub-module: rs_use_decode (opcode, func → use_rs1, use_rs2, is_jump, is_hlt). It is purely combinational and reused by forwarding_unit.

Test Plan:
- Load-use: LWD r1 in EX (ex_mem_read=1, ex_rd=1); ADD using rs1=1 in ID → one cycle with pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt=1; normal strobes the next cycle.
- No false stall: LHI in ID with ex_rd=id_rs1=2 and ex_mem_read=1 → no stall. NOT with rs2=ex_rd (rs1 differs) → no stall.
- Branch beats stall: ex_branch_taken=1 together with a load_use hit → ifid_flush=1, idex_bubble=1, pc_write=1; flush_cnt=1; stall_cnt unchanged.
- JMP in ID → ifid_flush=1 and idex_bubble=0 for one cycle; flush_cnt increments.
- HLT in ID → pc_write=0 from that cycle on; halt=1 exactly 3 cycles later and held for 10 more cycles. Then reset_n=1 for one cycle → halt=0 and state RUN.
- HLT drain abort: ex_branch_taken=1 one cycle after HLT enters DRAIN → flush strobes asserted, state returns to RUN, halt never asserts.
- Saturation: preload stall_cnt near the limit (CNT_W=4 build) with repeated stalls → the counter holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg
// Shared constants for the TSC hazard controller:
//   - opcode and ALU func encodings of the TSC instruction set
//   - hazard controller state encoding (RUN / DRAIN / HALTED)
// No ports; imported by rs_use_decode and pipeline_hazard_ctrl.
package pipeline_hazard_ctrl_pkg;

  // Major opcodes
  localparam logic [3:0] OPC_BNE = 4'd0;
  localparam logic [3:0] OPC_BEQ = 4'd1;
  localparam logic [3:0] OPC_BGZ = 4'd2;
  localparam logic [3:0] OPC_BLZ = 4'd3;
  localparam logic [3:0] OPC_ADI = 4'd4;
  localparam logic [3:0] OPC_ORI = 4'd5;
  localparam logic [3:0] OPC_LHI = 4'd6;
  localparam logic [3:0] OPC_LWD = 4'd7;
  localparam logic [3:0] OPC_SWD = 4'd8;
  localparam logic [3:0] OPC_JMP = 4'd9;
  localparam logic [3:0] OPC_JAL = 4'd10;
  localparam logic [3:0] OPC_ALU = 4'd15;

  // ALU_OP func codes
  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4;
  localparam logic [5:0] FN_TCP = 6'd5;
  localparam logic [5:0] FN_SHL = 6'd6;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  // Hazard controller states
  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_DRAIN  = 2'd1,
    HZ_HALTED = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_rs_use_decode.sv
// rs_use_decode
// Purely combinational decode of the ID-stage instruction into the
// facts the hazard logic needs. Also reused by forwarding_unit.
// Ports:
//   opcode_i  [3:0]  ID-stage opcode
//   func_i    [5:0]  ID-stage ALU func code
//   use_rs1_o        instruction reads rs1
//   use_rs2_o        instruction reads rs2
//   is_jump_o        JMP, JAL, JPR or JRL (resolved in ID)
//   is_hlt_o         HLT
module rs_use_decode
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic [5:0] func_i,
  output logic       use_rs1_o,
  output logic       use_rs2_o,
  output logic       is_jump_o,
  output logic       is_hlt_o
);

  // LHI, JMP, JAL and unused opcodes fall through to "reads nothing".
  always_comb begin
    use_rs1_o = 1'b0;
    use_rs2_o = 1'b0;
    is_jump_o = 1'b0;
    is_hlt_o  = 1'b0;
    case (opcode_i)
      OPC_ADI, OPC_ORI, OPC_LWD, OPC_BGZ, OPC_BLZ: begin
        use_rs1_o = 1'b1;
      end
      OPC_SWD, OPC_BNE, OPC_BEQ: begin
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
      end
      OPC_JMP, OPC_JAL: begin
        is_jump_o = 1'b1;
      end
      OPC_ALU: begin
        // Only the two-operand arithmetic/logic funcs read rs2.
        use_rs1_o = (func_i != FN_HLT);
        use_rs2_o = (func_i == FN_ADD) || (func_i == FN_SUB) ||
                    (func_i == FN_AND) || (func_i == FN_ORR);
        is_jump_o = (func_i == FN_JPR) || (func_i == FN_JRL);
        is_hlt_o  = (func_i == FN_HLT);
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and sequencing controller for the 5-stage TSC pipeline.
// Produces PC / IF/ID / ID/EX strobes for load-use stalls, control
// transfers and HLT drain, keeps the sticky halt flag and saturating
// stall/flush counters.
// Ports:
//   clk, reset_n          clock, synchronous active-high reset
//   id_opcode/id_func     ID-stage instruction decode fields
//   id_valid              ID-stage instruction is not a bubble
//   id_rs1/id_rs2         ID-stage source registers
//   ex_mem_read/ex_rd     EX-stage load indication and destination
//   ex_branch_taken       branch resolved taken in EX
//   pc_write/ifid_write   PC and IF/ID enables
//   ifid_flush            load bubble into IF/ID
//   idex_bubble           load bubble into ID/EX
//   halt                  sticky halted flag
//   stall_cnt/flush_cnt   saturating performance counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       id_opcode,
  input  logic [5:0]       id_func,
  input  logic             id_valid,
  input  logic [1:0]       id_rs1,
  input  logic [1:0]       id_rs2,
  input  logic             ex_mem_read,
  input  logic [1:0]       ex_rd,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  hz_state_e        state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             stall_inc, flush_inc;

  logic use_rs1, use_rs2, is_jump, is_hlt;
  logic load_use, id_jump, id_hlt;

  rs_use_decode u_decode (
    .opcode_i  (id_opcode),
    .func_i    (id_func),
    .use_rs1_o (use_rs1),
    .use_rs2_o (use_rs2),
    .is_jump_o (is_jump),
    .is_hlt_o  (is_hlt)
  );

  assign load_use = id_valid & ex_mem_read &
                    ((use_rs1 & (id_rs1 == ex_rd)) | (use_rs2 & (id_rs2 == ex_rd)));
  assign id_jump  = id_valid & is_jump;
  assign id_hlt   = id_valid & is_hlt;

  // Strobes and next state. The drain counter is loaded with
  // DRAIN_CYCLES-1 on the HLT edge and HALTED is entered on the edge
  // where it would count down to zero, so halt rises exactly
  // DRAIN_CYCLES edges after HLT was in ID.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    halt_d      = halt_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (reset_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (state_q)
        HZ_RUN: begin
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_inc   = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
          end else if (id_jump) begin
            ifid_flush  = 1'b1;
            flush_inc   = 1'b1;
          end else if (id_hlt) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            if (DRAIN_CYCLES <= 1) begin
              state_d = HZ_HALTED;
              halt_d  = 1'b1;
            end else begin
              state_d = HZ_DRAIN;
              drain_d = DW'(DRAIN_CYCLES - 1);
            end
          end
        end
        HZ_DRAIN: begin
          if (ex_branch_taken) begin
            // An older branch is resolving: the HLT was on a wrong path.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_inc   = 1'b1;
            state_d     = HZ_RUN;
            drain_d     = '0;
          end else begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (drain_q <= DW'(1)) begin
              state_d = HZ_HALTED;
              halt_d  = 1'b1;
              drain_d = '0;
            end else begin
              drain_d = drain_q - DW'(1);
            end
          end
        end
        HZ_HALTED: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
        default: begin
          state_d = HZ_RUN;
        end
      endcase
    end
    stall_d = (stall_inc && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
    flush_d = (flush_inc && (flush_q != '1)) ? flush_q + CNT_W'(1) : flush_q;
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= HZ_RUN;
      drain_q <= '0;
      halt_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      halt_q  <= halt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign halt      = halt_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule
